// File: rtl/inst_fetch_decode.sv
// Instruction fetch/decode front end: reads a 4-byte instruction from byte-wide program
// memory over a ready handshake, decodes it and strobes CORE_STEP once per instruction.
module inst_fetch_decode #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] PC,
    output logic [9:0] MEM_ADDR,
    output logic       MEM_RD,
    input  logic [7:0] MEM_DATA,
    input  logic       MEM_RDY,
    output logic       MEM_INST,
    output logic       ALU_INST,
    output logic       JMP_INST,
    output logic [1:0] MS,
    output logic       IRS,
    output logic [2:0] RS,
    output logic [2:0] AR,
    output logic [2:0] BS,
    output logic [3:0] OP,
    output logic [7:0] IMM,
    output logic       CORE_STEP,
    output logic       HALTED,
    output logic       FAULT
);

    localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        StFetch0, StFetch1, StFetch2, StFetch3, StExec, StHalt, StFault
    } state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [7:0]         pc_q, pc_d;
    logic [7:0]         b0_q, b0_d;
    logic [7:0]         b1_q, b1_d;
    logic [2:0]         bs_pend_q, bs_pend_d;
    logic               mem_rd_q, mem_rd_d;
    logic [1:0]         cls_q, cls_d;
    logic               halt_q, halt_d;
    logic [1:0]         ms_q, ms_d;
    logic               irs_q, irs_d;
    logic [2:0]         rs_q, rs_d;
    logic [2:0]         ar_q, ar_d;
    logic [2:0]         bs_q, bs_d;
    logic [3:0]         op_q, op_d;
    logic [7:0]         imm_q, imm_d;
    logic               fetching;
    logic               accept;

    assign fetching = (state_q == StFetch0) || (state_q == StFetch1) ||
                      (state_q == StFetch2) || (state_q == StFetch3);
    // MEM_RDY only counts while a request is actually outstanding.
    assign accept   = fetching && mem_rd_q && MEM_RDY;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        pc_d      = pc_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        bs_pend_d = bs_pend_q;
        cls_d     = cls_q;
        halt_d    = halt_q;
        ms_d      = ms_q;
        irs_d     = irs_q;
        rs_d      = rs_q;
        ar_d      = ar_q;
        bs_d      = bs_q;
        op_d      = op_q;
        imm_d     = imm_q;

        if (accept) begin
            wait_d = '0;
        end else if (fetching && mem_rd_q) begin
            if (wait_q == WaitW'(WAIT_LIMIT - 1)) begin
                state_d = StFault;
                wait_d  = '0;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        case (state_q)
            StFetch0: if (accept) begin
                pc_d    = PC;
                b0_d    = MEM_DATA;
                state_d = StFetch1;
            end
            StFetch1: if (accept) begin
                b1_d    = MEM_DATA;
                state_d = StFetch2;
            end
            StFetch2: if (accept) begin
                bs_pend_d = MEM_DATA[7:5];
                state_d   = StFetch3;
            end
            StFetch3: if (accept) begin
                cls_d   = b0_q[7:6];
                ms_d    = b0_q[5:4];
                irs_d   = b0_q[3];
                rs_d    = b0_q[2:0];
                op_d    = b1_q[7:4];
                ar_d    = b1_q[3:1];
                halt_d  = (b0_q[7:6] == 2'b11) && b1_q[0];
                bs_d    = bs_pend_q;
                imm_d   = MEM_DATA;
                state_d = StExec;
            end
            StExec:  state_d = halt_q ? StHalt : StFetch0;
            default: ;
        endcase

        mem_rd_d = (state_d == StFetch0) || (state_d == StFetch1) ||
                   (state_d == StFetch2) || (state_d == StFetch3);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= StFetch0;
            wait_q    <= '0;
            pc_q      <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            bs_pend_q <= '0;
            mem_rd_q  <= 1'b0;
            cls_q     <= '0;
            halt_q    <= 1'b0;
            ms_q      <= '0;
            irs_q     <= 1'b0;
            rs_q      <= '0;
            ar_q      <= '0;
            bs_q      <= '0;
            op_q      <= '0;
            imm_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            pc_q      <= pc_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            bs_pend_q <= bs_pend_d;
            mem_rd_q  <= mem_rd_d;
            cls_q     <= cls_d;
            halt_q    <= halt_d;
            ms_q      <= ms_d;
            irs_q     <= irs_d;
            rs_q      <= rs_d;
            ar_q      <= ar_d;
            bs_q      <= bs_d;
            op_q      <= op_d;
            imm_q     <= imm_d;
        end
    end

    // FETCH0 drives the live PC so the core's post-step Addr is used directly.
    always_comb begin
        case (state_q)
            StFetch0: MEM_ADDR = {PC, 2'b00};
            StFetch1: MEM_ADDR = {pc_q, 2'b01};
            StFetch2: MEM_ADDR = {pc_q, 2'b10};
            StFetch3: MEM_ADDR = {pc_q, 2'b11};
            default:  MEM_ADDR = {pc_q, 2'b00};
        endcase
    end

    assign MEM_RD    = mem_rd_q;
    assign CORE_STEP = (state_q == StExec);
    assign ALU_INST  = CORE_STEP && (cls_q == 2'b00);
    assign MEM_INST  = CORE_STEP && (cls_q == 2'b01);
    assign JMP_INST  = CORE_STEP && (cls_q == 2'b10);
    assign HALTED    = (state_q == StHalt);
    assign FAULT     = (state_q == StFault);
    assign MS        = ms_q;
    assign IRS       = irs_q;
    assign RS        = rs_q;
    assign AR        = ar_q;
    assign BS        = bs_q;
    assign OP        = op_q;
    assign IMM       = imm_q;

endmodule

// File: tb/tb_inst_fetch_decode.sv
// Directed bench for inst_fetch_decode: byte memory model with programmable ready latency.
module tb_inst_fetch_decode;

    logic       clk;
    logic       rst_n;
    logic [7:0] pc;
    logic [9:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data;
    logic       mem_rdy;
    logic       mem_inst, alu_inst, jmp_inst;
    logic [1:0] ms;
    logic       irs;
    logic [2:0] rs, ar, bs;
    logic [3:0] op;
    logic [7:0] imm;
    logic       core_step, halted, fault;

    logic [7:0] mem [1024];
    logic [7:0] wcnt;
    int         waits;
    logic       stall;
    int         checks;
    int         errors;

    inst_fetch_decode #(.WAIT_LIMIT(4)) dut (
        .CLK(clk), .RST_N(rst_n), .PC(pc), .MEM_ADDR(mem_addr), .MEM_RD(mem_rd),
        .MEM_DATA(mem_data), .MEM_RDY(mem_rdy), .MEM_INST(mem_inst), .ALU_INST(alu_inst),
        .JMP_INST(jmp_inst), .MS(ms), .IRS(irs), .RS(rs), .AR(ar), .BS(bs), .OP(op),
        .IMM(imm), .CORE_STEP(core_step), .HALTED(halted), .FAULT(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];
    assign mem_rdy  = mem_rd && (int'(wcnt) >= waits) && !stall;

    // Memory answers after `waits` stall cycles per byte.
    always_ff @(posedge clk) begin
        if (!mem_rd || mem_rdy) wcnt <= '0;
        else                    wcnt <= wcnt + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd"},   32'(mem_rd), 32'd0);
        check({tag, "_en"},   32'({mem_inst, alu_inst, jmp_inst, core_step}), 32'd0);
        check({tag, "_ctl"},  32'({ms, irs, rs, ar, bs, op}), 32'd0);
        check({tag, "_imm"},  32'(imm), 32'd0);
        check({tag, "_stat"}, 32'({halted, fault}), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stall  = 1'b0;
        waits  = 0;
        rst_n  = 1'b0;
        pc     = 8'h05;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        {mem[10'h014], mem[10'h015], mem[10'h016], mem[10'h017]} = {8'h0B, 8'h32, 8'hA0, 8'h7E};
        {mem[10'h000], mem[10'h001], mem[10'h002], mem[10'h003]} = {8'h80, 8'h70, 8'h00, 8'h09};
        {mem[10'h3FC], mem[10'h3FD], mem[10'h3FE], mem[10'h3FF]} = {8'h5A, 8'h9C, 8'hE0, 8'h33};
        {mem[10'h040], mem[10'h041], mem[10'h042], mem[10'h043]} = {8'hC0, 8'h00, 8'h00, 8'h00};
        {mem[10'h044], mem[10'h045], mem[10'h046], mem[10'h047]} = {8'hC0, 8'h01, 8'h00, 8'h00};

        // Reset state
        tick();
        tick();
        check_zero_outputs("reset");

        // ALU instruction, ready tied high: back-to-back bytes, EXEC on cycle 5
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("alu_addr", 32'(mem_addr), 32'h014 + i);
            check("alu_rd", 32'(mem_rd), 32'd1);
            tick();
        end
        check("alu_step", 32'({core_step, mem_inst, alu_inst, jmp_inst}), 32'b1010);
        check("alu_ms_irs_rs", 32'({ms, irs, rs}), 32'b00_1_011);
        check("alu_op_ar_bs", 32'({op, ar, bs}), {20'd0, 4'd3, 3'd1, 3'd5});
        check("alu_imm", 32'(imm), 32'h7E);
        check("alu_exec_rd", 32'(mem_rd), 32'd0);

        // JMP at PC 0 with three wait cycles per byte: EXEC on cycle 17
        pc    = 8'h00;
        waits = 3;
        tick();
        check("jmp_step_drop", 32'({core_step, alu_inst}), 32'd0);
        check("jmp_ctl_held", 32'(imm), 32'h7E);
        for (int i = 0; i < 16; i++) begin
            check("jmp_wait_addr", 32'(mem_addr), 32'(i / 4));
            check("jmp_wait_rd", 32'(mem_rd), 32'd1);
            tick();
        end
        check("jmp_step", 32'({core_step, mem_inst, alu_inst, jmp_inst}), 32'b1001);
        check("jmp_op", 32'(op), 32'd7);
        check("jmp_imm", 32'(imm), 32'd9);
        check("jmp_sel", 32'({ms, irs, rs, ar, bs}), 32'd0);

        // PC wrap corner: MEM instruction at PC 0xFF
        pc    = 8'hFF;
        waits = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("wrap_addr", 32'(mem_addr), 32'h3FC + i);
            tick();
        end
        check("wrap_step", 32'({core_step, mem_inst, alu_inst, jmp_inst}), 32'b1100);
        check("wrap_ms_irs_rs", 32'({ms, irs, rs}), 32'b01_1_010);
        check("wrap_op_ar_bs", 32'({op, ar, bs}), {20'd0, 4'd9, 3'd6, 3'd7});
        check("wrap_imm", 32'(imm), 32'h33);

        // SYS NOP then SYS HALT
        pc = 8'h10;
        tick();
        check("nop_addr", 32'(mem_addr), 32'h040);
        repeat (4) tick();
        check("nop_step", 32'({core_step, mem_inst, alu_inst, jmp_inst}), 32'b1000);
        pc = 8'h11;
        tick();
        check("nop_next", 32'({mem_rd, halted}), 32'b10);
        check("halt_addr", 32'(mem_addr), 32'h044);
        repeat (4) tick();
        check("halt_step", 32'({core_step, mem_inst, alu_inst, jmp_inst, halted}), 32'b10000);
        tick();
        check("halted", 32'({halted, core_step, mem_rd}), 32'b100);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_idle", 32'({halted, core_step, mem_rd}), 32'b100);
        end

        // Reset during FETCH2 abandons the partial instruction
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pc    = 8'h05;
        tick();
        tick();
        tick();
        check("midrst_f2_addr", 32'(mem_addr), 32'h016);
        rst_n = 1'b0;
        tick();
        check_zero_outputs("midrst");
        check("midrst_addr", 32'(mem_addr), 32'h014);
        rst_n = 1'b1;
        tick();
        check("refetch_addr", 32'(mem_addr), 32'h014);
        check("refetch_step", 32'(core_step), 32'd0);
        repeat (4) tick();
        check("refetch_exec", 32'({core_step, alu_inst}), 32'b11);
        check("refetch_imm", 32'(imm), 32'h7E);

        // Timeout in FETCH1 with WAIT_LIMIT=4
        tick();
        tick();
        stall = 1'b1;
        check("to_addr", 32'(mem_addr), 32'h015);
        repeat (3) tick();
        check("to_pre", 32'({fault, mem_rd}), 32'b01);
        tick();
        check("to_fault", 32'({fault, mem_rd, core_step}), 32'b100);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("to_sticky", 32'({fault, mem_rd, core_step}), 32'b100);
        end
        rst_n = 1'b0;
        tick();
        check("to_clear", 32'(fault), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
